// File: rtl/riscv_pkg.sv
// Shared definitions for the memory-port arbiter and its round-robin picker.
package riscv_pkg;

  // Arbiter state encoding, kept as plain constants for compatibility with
  // existing decode logic and waveform filters.
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;

  // Grant identifiers used for last-grant bookkeeping.
  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin selector: on conflict the side not granted last wins.
module rr_pick2
  import riscv_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last_grant,
  output logic gnt_i,
  output logic gnt_d
);

  // Lone requester always wins; a tie goes to the side not served last.
  always_comb begin
    gnt_i = req_i & (~req_d | (last_grant == GNT_D));
    gnt_d = req_d & (~req_i | (last_grant == GNT_I));
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between the I-cache and D-cache miss paths.
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W  = 30,
  parameter int unsigned LINE_W  = 128,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [LINE_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              timeout_flag
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(TIMEOUT);

  logic [1:0]        state_q, state_d;
  logic              last_q, last_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic              to_q, to_d;
  logic              gnt_i, gnt_d;

  rr_pick2 u_pick (
    .req_i      (i_req),
    .req_d      (d_read | d_write),
    .last_grant (last_q),
    .gnt_i      (gnt_i),
    .gnt_d      (gnt_d)
  );

  // Next-state: grant from IDLE, hold the bus until mem_ready, count stalls.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    read_d  = read_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wait_d  = wait_q;
    to_d    = to_q;
    case (state_q)
      IDLE: begin
        if (gnt_d) begin
          state_d = SERVE_D;
          last_d  = GNT_D;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          write_d = d_write;
          read_d  = d_read & ~d_write;
          wait_d  = '0;
        end else if (gnt_i) begin
          state_d = SERVE_I;
          last_d  = GNT_I;
          addr_d  = i_addr;
          write_d = 1'b0;
          read_d  = 1'b1;
          wait_d  = '0;
        end
      end
      SERVE_I, SERVE_D: begin
        // Returning to IDLE rather than re-granting here leaves one bubble
        // cycle so a requester's req, dropped after ready, is never re-served.
        if (mem_ready) begin
          state_d = IDLE;
          read_d  = 1'b0;
          write_d = 1'b0;
        end else if (wait_q != WAIT_MAX) begin
          wait_d = wait_q + 1'b1;
          if (wait_d == WAIT_MAX) begin
            to_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase
  end

  // Registered bus state with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= GNT_I;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wait_q  <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      read_q  <= read_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wait_q  <= wait_d;
      to_q    <= to_d;
    end
  end

  // Completion is routed combinationally from mem_ready to the current owner.
  always_comb begin
    i_ready      = mem_ready & (state_q == SERVE_I);
    d_ready      = mem_ready & (state_q == SERVE_D);
    i_rdata      = i_ready ? mem_rdata : '0;
    d_rdata      = d_ready ? mem_rdata : '0;
    mem_read     = read_q;
    mem_write    = write_q;
    mem_addr     = addr_q;
    mem_wdata    = wdata_q;
    busy         = (state_q != IDLE);
    timeout_flag = to_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level model plus
// directed scenarios with literal expectations.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 30;
  localparam int unsigned LW = 128;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req, d_read, d_write, mem_ready;
  logic [AW-1:0] i_addr, d_addr, mem_addr;
  logic [LW-1:0] d_wdata, mem_rdata, i_rdata, d_rdata, mem_wdata;
  logic          i_ready, d_ready, mem_read, mem_write, busy, timeout_flag;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Transaction model: who owns the bus (0 none, 1 I, 2 D), who won last,
  // what was put on the bus, and how many cycles the owner has stalled.
  int            m_owner;
  int            m_last;
  int            m_waits;
  logic          m_rd, m_wr, m_to;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= 0; m_last <= 1; m_waits <= 0;
      m_rd <= 1'b0; m_wr <= 1'b0; m_to <= 1'b0;
      m_addr <= '0; m_wdata <= '0;
    end else if (m_owner != 0) begin
      if (mem_ready) begin
        m_owner <= 0; m_rd <= 1'b0; m_wr <= 1'b0;
      end else begin
        m_waits <= m_waits + 1;
        if (m_waits + 1 >= TO) m_to <= 1'b1;
      end
    end else if ((d_read || d_write) && (!i_req || m_last == 1)) begin
      m_owner <= 2; m_last <= 2; m_waits <= 0;
      m_addr <= d_addr; m_wdata <= d_wdata;
      m_wr <= d_write; m_rd <= d_read && !d_write;
    end else if (i_req) begin
      m_owner <= 1; m_last <= 1; m_waits <= 0;
      m_addr <= i_addr; m_rd <= 1'b1; m_wr <= 1'b0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("cmp_busy", busy, m_owner != 0);
    chk("cmp_mem_read", mem_read, m_rd);
    chk("cmp_mem_write", mem_write, m_wr);
    chk("cmp_mem_addr", mem_addr, m_addr);
    chk("cmp_mem_wdata", mem_wdata, m_wdata);
    chk("cmp_timeout", timeout_flag, m_to);
    chk("cmp_i_ready", i_ready, m_owner == 1 && mem_ready);
    chk("cmp_d_ready", d_ready, m_owner == 2 && mem_ready);
    chk("cmp_i_rdata", i_rdata, (m_owner == 1 && mem_ready) ? mem_rdata : '0);
    chk("cmp_d_rdata", d_rdata, (m_owner == 2 && mem_ready) ? mem_rdata : '0);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; i_req = 0; d_read = 0; d_write = 0; mem_ready = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    cyc(2);
    chk("rst_busy", busy, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_timeout", timeout_flag, 0);
    chk("rst_i_rdata", i_rdata, 0);
    rst_n = 1'b1;
    cyc(1);

    // Lone I read, memory acks on the third serve cycle.
    i_req = 1; i_addr = 30'h100;
    cyc(1);
    chk("i_mem_read", mem_read, 1);
    chk("i_mem_addr", mem_addr, 30'h100);
    cyc(2);
    mem_ready = 1; mem_rdata = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    #1;
    chk("i_ready_pulse", i_ready, 1);
    chk("i_rdata_val", i_rdata, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF);
    cyc(1);
    mem_ready = 0; i_req = 0;
    chk("i_busy_fall", busy, 0);
    cyc(1);

    // D write.
    d_write = 1; d_addr = 30'h2A; d_wdata = 128'h1234;
    cyc(1);
    chk("dw_mem_write", mem_write, 1);
    chk("dw_mem_read", mem_read, 0);
    chk("dw_mem_wdata", mem_wdata, 128'h1234);
    cyc(1);
    mem_ready = 1; mem_rdata = 128'h5;
    #1;
    chk("dw_d_ready", d_ready, 1);
    chk("dw_i_ready", i_ready, 0);
    cyc(1);
    mem_ready = 0; d_write = 0;
    cyc(1);

    // Read and write together behave as a write.
    d_read = 1; d_write = 1; d_addr = 30'h3C; d_wdata = 128'hABCD;
    cyc(1);
    chk("drw_mem_write", mem_write, 1);
    chk("drw_mem_read", mem_read, 0);
    mem_ready = 1;
    cyc(1);
    mem_ready = 0; d_read = 0; d_write = 0;
    cyc(1);

    // Conflict after reset: D first, then I and D alternate.
    do_reset();
    i_req = 1; i_addr = 30'h11; d_read = 1; d_addr = 30'h22;
    cyc(1);
    chk("cf1_mem_addr_d", mem_addr, 30'h22);
    cyc(1);
    mem_ready = 1; mem_rdata = 128'h77;
    #1;
    chk("cf1_d_ready", d_ready, 1);
    chk("cf1_i_ready", i_ready, 0);
    cyc(1);
    mem_ready = 0; d_addr = 30'h33;
    chk("cf1_bubble", busy, 0);
    cyc(1);
    chk("cf2_mem_addr_i", mem_addr, 30'h11);
    mem_ready = 1; mem_rdata = 128'h99;
    #1;
    chk("cf2_i_ready", i_ready, 1);
    cyc(1);
    mem_ready = 0; i_req = 0;
    cyc(2);
    chk("cf3_mem_addr_d", mem_addr, 30'h33);
    mem_ready = 1;
    cyc(1);
    mem_ready = 0; d_read = 0;
    cyc(1);

    // Long stall: timeout after TO wait cycles, sticky past the ack.
    do_reset();
    i_req = 1; i_addr = 30'h1F0;
    cyc(1);
    cyc(TO - 1);
    chk("to_not_yet", timeout_flag, 0);
    cyc(1);
    chk("to_set", timeout_flag, 1);
    chk("to_strobe_held", mem_read, 1);
    cyc(4);
    chk("to_addr_held", mem_addr, 30'h1F0);
    mem_ready = 1;
    cyc(1);
    mem_ready = 0; i_req = 0;
    cyc(1);
    chk("to_sticky", timeout_flag, 1);

    // Asynchronous reset in the middle of a D transaction.
    do_reset();
    d_write = 1; d_addr = 30'h55; d_wdata = 128'hF00D;
    cyc(1);
    chk("ar_pre_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_busy_drop", busy, 0);
    chk("ar_write_drop", mem_write, 0);
    chk("ar_addr_clr", mem_addr, 0);
    d_write = 0;
    @(posedge clk); #1;
    rst_n = 1'b1; mem_ready = 1; mem_rdata = 128'hBAD;
    #1;
    chk("ar_stray_d_ready", d_ready, 0);
    chk("ar_stray_i_ready", i_ready, 0);
    cyc(1);
    mem_ready = 0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
